// File: rtl/mon_pkg.sv
// Shared types for the bus write monitor: the buffered store record and
// the monitor FSM state encoding.
package mon_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_rec_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } mon_state_t;

  function automatic wr_rec_t make_rec(input logic [15:0] addr, input logic [7:0] data);
    wr_rec_t r;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/wr_fifo.sv
// Write-record FIFO. The head entry is read straight out of the storage
// array, so it is valid in the same cycle the entry becomes the oldest one.
// A push while full is accepted only when a pop frees a slot in that cycle;
// otherwise the record is dropped and drop_o pulses.
module wr_fifo
  import mon_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  logic    pop_i,
  input  wr_rec_t din_i,
  output wr_rec_t head_o,
  output logic    full_o,
  output logic    empty_o,
  output logic    drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  wr_rec_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of 2).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Record storage; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/bus_write_monitor.sv
// Passive CPU store monitor: buffers every store for a log consumer, counts
// stores, and on a self-jump halt checks the last value written to the
// signature address.
// Optional build macro: MON_TIMEOUT_EN adds a RUN-state watchdog that ends
// the test with fail after TIMEOUT cycles.
//
//  state | meaning
//  RUN   | capturing stores, watching opcode fetches for a halt
//  CHECK | one cycle: compare signature, stores ignored
//  DONE  | verdict latched until reset, FIFO still drains
module bus_write_monitor
  import mon_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter int          HALT_REPEAT = 3,
  parameter logic [15:0] CHECK_ADDR  = 16'h0021,
  parameter logic [7:0]  EXPECT      = 8'h0C,
  parameter int          TIMEOUT     = 4096
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_sync,
  input  logic        log_ready,
  output logic        log_valid,
  output logic [15:0] log_addr,
  output logic [7:0]  log_data,
  output logic [15:0] wr_count,
  output logic        overflow,
  output logic        done,
  output logic        pass,
  output logic        fail
);

  localparam int RW = (HALT_REPEAT > 1) ? $clog2(HALT_REPEAT + 1) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(HALT_REPEAT);

  mon_state_t     state_q, state_d;
  logic           done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic [15:0]    wr_count_q, wr_count_d;
  logic           overflow_q, overflow_d;
  logic           sig_seen_q, sig_seen_d;
  logic [7:0]     sig_val_q, sig_val_d;
  logic [15:0]    last_fetch_q, last_fetch_d;
  logic [RW-1:0]  rep_cnt_q, rep_cnt_d;
  logic           halt, check_ok, timeout_hit;
  logic           store_ok, pop;
  wr_rec_t        head;
  logic           fifo_full, fifo_empty, fifo_drop;

  assign store_ok = cpu_we && (state_q == RUN);
  assign pop      = log_valid && log_ready;
  assign check_ok = sig_seen_q && (sig_val_q == EXPECT);

  wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (ph1),
    .rst_i   (reset),
    .push_i  (store_ok),
    .pop_i   (pop),
    .din_i   (make_rec(cpu_addr, cpu_wdata)),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  assign log_valid = !fifo_empty;
  assign log_addr  = fifo_empty ? 16'h0000 : head.addr;
  assign log_data  = fifo_empty ? 8'h00    : head.data;
  assign wr_count  = wr_count_q;
  assign overflow  = overflow_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

`ifdef MON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cyc_q, cyc_d;

  // Watchdog counts RUN cycles only; it fires on the TIMEOUT-th one.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == RUN) cyc_d = cyc_q + TW'(1);
  end

  assign timeout_hit = (state_q == RUN) && (cyc_q == TW'(TIMEOUT - 1));

  // Watchdog register.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end
`else
  // TIMEOUT has no effect in this build.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  // Store capture, signature tracking and halt detection next-state.
  always_comb begin
    wr_count_d   = wr_count_q;
    overflow_d   = overflow_q | fifo_drop;
    sig_seen_d   = sig_seen_q;
    sig_val_d    = sig_val_q;
    last_fetch_d = last_fetch_q;
    rep_cnt_d    = rep_cnt_q;
    halt         = 1'b0;
    if (store_ok) begin
      if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
      if (cpu_addr == CHECK_ADDR) begin
        sig_seen_d = 1'b1;
        sig_val_d  = cpu_wdata;
      end
    end
    if ((state_q == RUN) && cpu_sync) begin
      if (cpu_addr == last_fetch_q) begin
        rep_cnt_d = (rep_cnt_q == REP_MAX) ? REP_MAX : rep_cnt_q + RW'(1);
      end else begin
        rep_cnt_d    = RW'(1);
        last_fetch_d = cpu_addr;
      end
      halt = (rep_cnt_d == REP_MAX);
    end
  end

  // Datapath registers.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      wr_count_q   <= '0;
      overflow_q   <= 1'b0;
      sig_seen_q   <= 1'b0;
      sig_val_q    <= '0;
      last_fetch_q <= '0;
      rep_cnt_q    <= '0;
    end else begin
      wr_count_q   <= wr_count_d;
      overflow_q   <= overflow_d;
      sig_seen_q   <= sig_seen_d;
      sig_val_q    <= sig_val_d;
      last_fetch_q <= last_fetch_d;
      rep_cnt_q    <= rep_cnt_d;
    end
  end

  // FSM next state and verdict; halt outranks a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      RUN: begin
        if (halt) begin
          state_d = CHECK;
        end else if (timeout_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 1'b1;
        end
      end
      CHECK: begin
        state_d = DONE;
        done_d  = 1'b1;
        pass_d  = check_ok;
        fail_d  = !check_ok;
      end
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  // FSM and verdict registers.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

endmodule

// File: tb/tb_bus_write_monitor.sv
// Directed bench for bus_write_monitor (DEPTH=8, HALT_REPEAT=3,
// CHECK_ADDR=0x0021, EXPECT=0x0C, TIMEOUT=50).
module tb_bus_write_monitor;

  logic        ph1 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_sync = 1'b0;
  logic        log_ready = 1'b0;
  logic        log_valid;
  logic [15:0] log_addr;
  logic [7:0]  log_data;
  logic [15:0] wr_count;
  logic        overflow, done, pass, fail;

  int n_tests = 0;
  int n_fail  = 0;

  bus_write_monitor #(
    .DEPTH(8), .HALT_REPEAT(3), .CHECK_ADDR(16'h0021), .EXPECT(8'h0C), .TIMEOUT(50)
  ) dut (
    .ph1(ph1), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_sync(cpu_sync), .log_ready(log_ready),
    .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
    .wr_count(wr_count), .overflow(overflow), .done(done), .pass(pass), .fail(fail)
  );

  always #5 ph1 = ~ph1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ph1);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_we = 1'b0;
    cpu_sync = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic store(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1; cpu_sync = 1'b0;
    cyc();
    cpu_we = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] a);
    cpu_addr = a; cpu_sync = 1'b1; cpu_we = 1'b0;
    cyc();
    cpu_sync = 1'b0;
  endtask

  task automatic chk_verdict(input string tag, input logic d, input logic p, input logic f);
    chk({tag, "_done"}, done, d);
    chk({tag, "_pass"}, pass, p);
    chk({tag, "_fail"}, fail, f);
  endtask

  initial begin
    cyc(); cyc();
    reset = 1'b0;

    // Reset state
    chk("rst_valid", log_valid, 0);
    chk("rst_addr", log_addr, 0);
    chk("rst_data", log_data, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_ovf", overflow, 0);
    chk_verdict("rst", 0, 0, 0);

    // Passing signature, then halt
    log_ready = 1'b1;
    store(16'h0021, 8'h0C);
    chk("t1_valid", log_valid, 1);
    chk("t1_addr", log_addr, 16'h0021);
    chk("t1_data", log_data, 8'h0C);
    chk("t1_count", wr_count, 1);
    fetch(16'hF010); fetch(16'hF010); fetch(16'hF010);
    chk("t1_check_cycle_done", done, 0);
    cyc();
    chk_verdict("t1", 1, 1, 0);
    chk("t1_drained", log_valid, 0);
    store(16'h0030, 8'h55);
    chk("t1_store_after_done", wr_count, 1);
    chk("t1_no_push_after_done", log_valid, 0);
    do_reset();
    chk_verdict("t1_reset", 0, 0, 0);

    // Wrong final signature (last write wins), then never-written signature
    store(16'h0021, 8'h0C);
    store(16'h0021, 8'h0B);
    fetch(16'hF010); fetch(16'hF010); fetch(16'hF010);
    cyc();
    chk_verdict("t2a", 1, 0, 1);
    do_reset();
    store(16'h0022, 8'h0C);
    fetch(16'hF010); fetch(16'hF010); fetch(16'hF010);
    cyc();
    chk_verdict("t2b", 1, 0, 1);
    do_reset();

    // Store in the same cycle as the halting fetch still counts
    fetch(16'h0021); fetch(16'h0021);
    cpu_addr = 16'h0021; cpu_wdata = 8'h0C; cpu_we = 1'b1; cpu_sync = 1'b1;
    cyc();
    cpu_we = 1'b0; cpu_sync = 1'b0;
    chk("t2c_count", wr_count, 1);
    cyc();
    chk_verdict("t2c", 1, 1, 0);
    do_reset();

    // Overflow: 9 stores into 8 entries with consumer stalled
    log_ready = 1'b0;
    for (int i = 0; i < 9; i++) store(16'h1000 + 16'(i), 8'h10 + 8'(i));
    chk("t3_ovf", overflow, 1);
    chk("t3_count", wr_count, 9);
    log_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_addr%0d", i), log_addr, 16'h1000 + 16'(i));
      chk($sformatf("t3_data%0d", i), log_data, 8'h10 + 8'(i));
      cyc();
    end
    chk("t3_empty", log_valid, 0);
    chk("t3_ovf_sticky", overflow, 1);
    do_reset();
    chk("t3_ovf_reset", overflow, 0);

    // Full FIFO: push and pop together
    log_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(16'h2000 + 16'(i), 8'h20 + 8'(i));
    chk("t4_full_no_ovf", overflow, 0);
    log_ready = 1'b1;
    store(16'h2008, 8'h28);
    chk("t4_ovf", overflow, 0);
    chk("t4_count", wr_count, 9);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t4_addr%0d", i), log_addr, 16'h2000 + 16'(i));
      chk($sformatf("t4_data%0d", i), log_data, 8'h20 + 8'(i));
      cyc();
    end
    chk("t4_empty", log_valid, 0);
    do_reset();

    // Repeat counter restarts on a different fetch address
    fetch(16'hF010); fetch(16'hF010); fetch(16'hF013); fetch(16'hF010);
    cyc(); cyc();
    chk("t5_no_halt", done, 0);
    fetch(16'hF010);
    cyc();
    chk("t5_two_only", done, 0);
    fetch(16'hF010);
    cyc();
    chk_verdict("t5", 1, 0, 1);
    store(16'h0021, 8'h0C);
    chk("t5_store_after_done", wr_count, 0);
    chk_verdict("t5_hold", 1, 0, 1);
    do_reset();

    // Asynchronous reset mid-run
    log_ready = 1'b0;
    for (int i = 0; i < 9; i++) store(16'h3000 + 16'(i), 8'h30 + 8'(i));
    chk("t6_pre_ovf", overflow, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", log_valid, 0);
    chk("t6_async_count", wr_count, 0);
    chk("t6_async_ovf", overflow, 0);
    chk("t6_async_addr", log_addr, 0);
    cyc();
    reset = 1'b0;

`ifdef MON_TIMEOUT_EN
    // Watchdog fires on the 50th RUN cycle
    for (int i = 0; i < 49; i++) cyc();
    chk("t6_before_timeout", done, 0);
    cyc();
    chk_verdict("t6_timeout", 1, 0, 1);
    do_reset();
    chk_verdict("t6_timeout_reset", 0, 0, 0);
`else
    // No watchdog in this build: idling never ends the test
    for (int i = 0; i < 60; i++) cyc();
    chk_verdict("t6_no_timeout", 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
